control_unit_v2: RTL
====================

Name: control_unit_v2

Overview:
Parametrised successor to the accumulator control unit. Same fetch/exec ISA, now with a synchronous active-low reset and a single request/ready memory bus that tolerates wait states. Adds a bounded hardware stack with overflow/underflow detection, illegal-opcode trapping, and halt/fault status outputs in place of simulation-only termination. Sits between the top level and the shared RAM block as the sole bus master.

Parameters:
ADDR_SIZE, 12, address and PC width; must be <= WORD_SIZE-4
WORD_SIZE, 16, data/instruction width; opcode = ir[WORD_SIZE-1:WORD_SIZE-4], operand S = ir[ADDR_SIZE-1:0]
RESET_PC, 0, PC value after reset
STACK_BASE, 128, first stack word address; stack grows upward
STACK_DEPTH, 64, maximum number of stacked words

Ports:
sysclk  in  1  system clock; all state updates on rising edge
sysrst_n  in  1  synchronous active-low reset
mem_req  out  1  bus request
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_SIZE  bus address
mem_wdata  out  WORD_SIZE  write data
mem_rdata  in  WORD_SIZE  read data, valid in the mem_ready cycle
mem_ready  in  1  transfer completes in the cycle mem_req=1 and mem_ready=1
acc_out  out  WORD_SIZE  accumulator
pc_out  out  ADDR_SIZE  program counter
halted  out  1  HALT executed
fault  out  1  fault trap taken
fault_code  out  2  1=stack overflow, 2=stack underflow, 3=illegal opcode; 0 otherwise

Behaviour:
- Reset (sysrst_n=0 at edge): state=FETCH_REQ, pc=RESET_PC, acc=0, sp=STACK_BASE, ir=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, fault=0, fault_code=0. Reset overrides an in-flight transfer; mem_req is 0 in the cycle after the reset edge.
- Bus outputs are registered. mem_addr, mem_we and mem_wdata hold stable while mem_req=1 and mem_ready=0. mem_req deasserts in the cycle after the completing ready. There are no back-to-back requests.
- FSM: FETCH_REQ -> FETCH_WAIT -> EXEC -> [MEM_WAIT] -> FETCH_REQ. HALT and FAULT are terminal; only reset leaves them.
- FETCH_REQ: drive mem_req=1, we=0, addr=pc.
- FETCH_WAIT: on ready, ir<=mem_rdata and pc<=pc+1 (mod 2^ADDR_SIZE).
- EXEC: non-memory ops complete in one cycle, then FETCH_REQ.
- Opcodes:
  - 0: LOAD acc:=[S]
  - 1: STORE [S]:=acc
  - 2: ADD acc:=acc+[S]
  - 3: SUB acc:=acc-[S]
  - 4: JMP pc:=S
  - 5: JGE, pc:=S if acc[WORD_SIZE-1]=0
  - 6: JNZ, pc:=S if acc!=0
  - 7: HALT
  - 8: PUSH [sp]:=acc, sp:=sp+1
  - 9: POP sp:=sp-1, acc:=[sp-1]
  - A-F: illegal
- Memory ops (0,1,2,3,8,9) issue one bus transfer from EXEC and wait in MEM_WAIT. acc and sp update in the ready cycle only.
- Minimum cycles per instruction: 3 for non-memory ops, 5 for memory ops, plus any wait states.
- Arithmetic wraps modulo 2^WORD_SIZE. No flags are kept.
- Stack bounds are checked in EXEC before any bus request:
  - PUSH with sp==STACK_BASE+STACK_DEPTH -> FAULT, code 1.
  - POP with sp==STACK_BASE -> FAULT, code 2.
  - Illegal opcode -> FAULT, code 3.
  - On a fault, no bus transfer occurs and acc, sp and pc are unchanged (pc already points past the faulting word).
- HALT: halted=1 from the cycle after EXEC, mem_req stays 0, and state is frozen.

Optional Feature:
CONTROL_UNIT_CALL_RET_EN
- Defined:
  - Opcode A (CALL S) pushes pc (already incremented, zero-extended to WORD_SIZE), then sets pc:=S. Same overflow check and 5-cycle timing as PUSH.
  - Opcode B (RET) pops into pc (low ADDR_SIZE bits); acc is unchanged. Same underflow check and timing as POP.
- Undefined: A and B are illegal (fault code 3).

Test Plan:
- Ready tied high. Program: LOAD 0x100 ([0x100]=5), ADD 0x101 ([0x101]=7), STORE 0x102, HALT -> [0x102]=12, halted=1, pc_out=4, 18 cycles from reset release to halted.
- mem_ready delayed 3 cycles per transfer -> mem_addr/we/wdata stable throughout each wait; same final result as the zero-wait run.
- acc=0x8000, JGE 0x20 -> not taken. Then SUB to acc=0, JNZ 0x20 -> not taken. Then acc=1, JNZ 0x20 -> pc_out=0x20.
- Defaults: 64 PUSHes succeed, sp=192. 65th PUSH -> fault=1, fault_code=1, no write issued. After reset, POP -> fault_code=2.
- Assert reset while mem_req=1 and mem_ready=0 -> next cycle mem_req=0, pc_out=0, acc_out=0. Execution restarts cleanly.
- Opcode 0xA: with the macro, CALL 0x40 then RET -> pc returns to CALL address+1. Without the macro -> fault_code=3.

Source files
------------

// File: rtl/control_unit_v2.sv
// control_unit_v2: accumulator CPU bus master with wait-state bus, bounded stack and fault traps.
// Optional CALL/RET (opcodes A/B) enabled by defining CONTROL_UNIT_CALL_RET_EN.
module control_unit_v2 #(
    parameter int ADDR_SIZE   = 12,
    parameter int WORD_SIZE   = 16,
    parameter int RESET_PC    = 0,
    parameter int STACK_BASE  = 128,
    parameter int STACK_DEPTH = 64
) (
    input  logic                 sysclk,
    input  logic                 sysrst_n,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] acc_out,
    output logic [ADDR_SIZE-1:0] pc_out,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code
);
    typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, MEM_WAIT, HALT, FAULT} state_t;
    localparam logic [ADDR_SIZE-1:0] SP_LO = ADDR_SIZE'(STACK_BASE);
    localparam logic [ADDR_SIZE-1:0] SP_HI = ADDR_SIZE'(STACK_BASE + STACK_DEPTH);
    state_t               state_q;
    logic [ADDR_SIZE-1:0] pc_q, sp_q, addr_q;
    logic [WORD_SIZE-1:0] acc_q, ir_q, wdata_q;
    logic                 req_q, we_q, halted_q, fault_q;
    logic [1:0]           code_q;
    logic [3:0]           op;
    logic [ADDR_SIZE-1:0] s, addr_d, pc_d;
    logic [WORD_SIZE-1:0] acc_d, wdata_d;
    logic                 is_push, is_pop, is_mem, legal, take, we_d;
    always_comb begin
        op      = ir_q[WORD_SIZE-1:WORD_SIZE-4];
        s       = ir_q[ADDR_SIZE-1:0];
`ifdef CONTROL_UNIT_CALL_RET_EN
        is_push = op == 4'h8 || op == 4'hA;
        is_pop  = op == 4'h9 || op == 4'hB;
        legal   = op <= 4'hB;
        wdata_d = op == 4'hA ? WORD_SIZE'(pc_q) : acc_q;
        pc_d    = op == 4'hA ? s : op == 4'hB ? mem_rdata[ADDR_SIZE-1:0] : pc_q;
`else
        is_push = op == 4'h8;
        is_pop  = op == 4'h9;
        legal   = op <= 4'h9;
        wdata_d = acc_q;
        pc_d    = pc_q;
`endif
        is_mem  = op <= 4'h3 || is_push || is_pop;
        take    = op == 4'h4 || (op == 4'h5 && !acc_q[WORD_SIZE-1]) || (op == 4'h6 && acc_q != '0);
        addr_d  = is_push ? sp_q : is_pop ? sp_q - 1'b1 : s;
        we_d    = op == 4'h1 || is_push;
        acc_d   = (op == 4'h0 || op == 4'h9) ? mem_rdata :
                  op == 4'h2 ? acc_q + mem_rdata :
                  op == 4'h3 ? acc_q - mem_rdata : acc_q;
    end
    always_ff @(posedge sysclk) begin
        if (!sysrst_n) begin
            state_q  <= FETCH_REQ;
            pc_q     <= ADDR_SIZE'(RESET_PC);
            sp_q     <= SP_LO;
            acc_q    <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    req_q   <= 1'b1;
                    we_q    <= 1'b0;
                    addr_q  <= pc_q;
                    state_q <= FETCH_WAIT;
                end
                FETCH_WAIT: if (mem_ready) begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_q + 1'b1;
                    req_q   <= 1'b0;
                    state_q <= EXEC;
                end
                EXEC: begin
                    // Traps are decided here so a faulting op never reaches the bus.
                    if (!legal || (is_push && sp_q == SP_HI) || (is_pop && sp_q == SP_LO)) begin
                        fault_q <= 1'b1;
                        code_q  <= !legal ? 2'd3 : is_push ? 2'd1 : 2'd2;
                        state_q <= FAULT;
                    end else if (is_mem) begin
                        addr_q  <= addr_d;
                        we_q    <= we_d;
                        wdata_q <= wdata_d;
                        state_q <= MEM_WAIT;
                    end else begin
                        pc_q     <= take ? s : pc_q;
                        halted_q <= op == 4'h7;
                        state_q  <= op == 4'h7 ? HALT : FETCH_REQ;
                    end
                end
                MEM_WAIT: begin
                    // First cycle only raises the request; completion needs req and ready together.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (mem_ready) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        acc_q   <= acc_d;
                        pc_q    <= pc_d;
                        sp_q    <= is_push ? sp_q + 1'b1 : is_pop ? sp_q - 1'b1 : sp_q;
                        state_q <= FETCH_REQ;
                    end
                end
                default: ;
            endcase
        end
    end
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign acc_out    = acc_q;
    assign pc_out     = pc_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
endmodule
